// File: rtl/uart_ctrl_pkg.sv
// ============================================================================
// Module      : uart_ctrl_pkg
// Description : Shared UART controller types, defaults and parity helper.
//               Imported by the tx arbiter and the tx/rx agent BFMs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_ctrl_pkg;

    localparam int c_default_baud_div   = 16;
    localparam int c_default_data_width = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_tx_state_e;

    // Narrower bytes are zero-extended by the caller, which leaves the parity unchanged.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester handshake bundle and serial output of the UART
//               transmit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) ();
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [$clog2(NUM_REQ)-1:0]    grant_id;
    logic                          busy;
    logic                          tx;

    modport master (
        output req_valid, req_data,
        input  req_ready, grant_id, busy, tx
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, grant_id, busy, tx
    );
endinterface

`default_nettype wire

// File: rtl/uart_baud_counter.sv
// ============================================================================
// Module      : uart_baud_counter
// Description : Free-running 0..BAUD_DIV-1 counter with synchronous clear and
//               a one-cycle bit_tick on the terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_counter #(
    parameter int BAUD_DIV = 16
) (
    input  wire  clk,
    input  wire  areset,
    input  wire  i_clear,
    output logic o_bit_tick
);
    localparam int c_cnt_w = $clog2(BAUD_DIV);

    logic [c_cnt_w-1:0] r_cnt;

    assign o_bit_tick = (r_cnt == c_cnt_w'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_cnt <= '0;
        end else if (i_clear || o_bit_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end
endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one UART tx line between NUM_REQ
//               requesters. Define UART_TX_ARB_PARITY_EN for an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = c_default_data_width,
    parameter int BAUD_DIV   = c_default_baud_div,
    parameter int STOP_BITS  = 1
) (
    input wire               pclk,
    input wire               areset,
    uart_tx_arbiter_if.slave bus
);
    localparam int c_id_w  = $clog2(NUM_REQ);
    localparam int c_cnt_w = $clog2(DATA_WIDTH);
`ifdef UART_TX_ARB_PARITY_EN
    localparam uart_tx_state_e c_after_data = S_PARITY;
`else
    localparam uart_tx_state_e c_after_data = S_STOP;
`endif

    uart_tx_state_e          r_state, w_state_next;
    logic [DATA_WIDTH-1:0]   r_shift, w_shift_next;
    logic [c_cnt_w-1:0]      r_bit_cnt, w_bit_cnt_next;
    logic [c_id_w-1:0]       r_ptr, r_grant_id, w_sel, w_cand;
    logic                    r_tx, w_tx_next;
    logic                    w_found, w_grant, w_bit_tick;
    logic [DATA_WIDTH-1:0]   w_sel_data;
`ifdef UART_TX_ARB_PARITY_EN
    logic                    r_parity;
`endif

    uart_baud_counter #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk        (pclk),
        .areset     (areset),
        .i_clear    (r_state == S_IDLE),
        .o_bit_tick (w_bit_tick)
    );

    // First pending requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(r_ptr) + k >= NUM_REQ) begin
                w_cand = c_id_w'(int'(r_ptr) + k - NUM_REQ);
            end else begin
                w_cand = c_id_w'(int'(r_ptr) + k);
            end
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    assign w_grant       = w_found && (r_state == S_IDLE) && areset;
    assign w_sel_data    = bus.req_data[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
    assign bus.req_ready = w_grant ? (NUM_REQ'(1) << w_sel) : '0;
    assign bus.grant_id  = r_grant_id;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.tx        = r_tx;

    // tx is registered from the next-state view so the pin never glitches.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_tx_next      = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_next   = S_START;
                    w_shift_next   = w_sel_data;
                    w_bit_cnt_next = '0;
                end
            end
            S_START: begin
                if (w_bit_tick) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_tick) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == c_cnt_w'(DATA_WIDTH - 1)) begin
                        w_state_next   = c_after_data;
                        w_bit_cnt_next = '0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + c_cnt_w'(1);
                    end
                end
            end
`ifdef UART_TX_ARB_PARITY_EN
            S_PARITY: begin
                if (w_bit_tick) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_tick) begin
                    if (r_bit_cnt == c_cnt_w'(STOP_BITS - 1)) begin
                        w_state_next   = S_IDLE;
                        w_bit_cnt_next = '0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + c_cnt_w'(1);
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
`ifdef UART_TX_ARB_PARITY_EN
            S_PARITY: w_tx_next = r_parity;
`endif
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_tx       <= 1'b1;
`ifdef UART_TX_ARB_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_tx      <= w_tx_next;
            if (w_grant) begin
                r_grant_id <= w_sel;
                r_ptr      <= (w_sel == c_id_w'(NUM_REQ - 1)) ? '0 : w_sel + c_id_w'(1);
`ifdef UART_TX_ARB_PARITY_EN
                r_parity   <= even_parity(8'(w_sel_data));
`endif
            end
        end
    end
endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmit line between NUM_REQ requesters: round-robin arbitration, then sequencing of the granted byte through start, data, optional parity and stop bits at a fixed baud divisor. Sits between the device-side requesters and the `tx` pin of `uart_if`. Serves as both the DUT-side transmit controller and the reference model the tx agent BFM drives against.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, data bits per frame (5..8)
- BAUD_DIV, 16, pclk cycles per serial bit (>= 2)
- STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
- pclk  in  1  system clock; all logic on posedge
- areset  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester byte-pending flag
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester byte; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  one-hot accept pulse
- grant_id  out  $clog2(NUM_REQ)  index of last granted requester
- busy  out  1  high while a frame is on the line
- tx  out  1  serial output, idle high

## Operation
- Reset values: tx=1, busy=0, req_ready=0, grant_id=0, round-robin pointer=0, FSM=IDLE, baud and bit counters=0.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - tx=1 and busy=0.
  - If any req_valid is set, pick the first set bit searching from pointer, wrapping modulo NUM_REQ.
  - In that same cycle: assert req_ready[i] for one cycle, latch req_data slice i, set grant_id=i, set pointer=(i+1) mod NUM_REQ, and move to START.
- START: tx=0 for BAUD_DIV cycles.
- DATA: DATA_WIDTH bits, LSB first, each held BAUD_DIV cycles.
- PARITY (only when enabled): even parity over the latched byte, held BAUD_DIV cycles.
- STOP: tx=1 for STOP_BITS*BAUD_DIV cycles, then IDLE.
- busy=1 in every state except IDLE.
- Baud counter:
  - Counts 0..BAUD_DIV-1 and wraps.
  - A state or bit advance happens on the cycle the counter equals BAUD_DIV-1.
  - The counter is cleared on grant.
- Requests are level-sensitive and not stored. Deasserting req_valid before grant drops the request; no stale grant may follow.
- req_valid or req_data changes during a frame do not affect the frame in flight.
- A requester with req_valid held high is re-eligible at the next IDLE cycle.
- Simultaneous requests are served in rotating order, e.g. all four asserted gives 0,1,2,3,0...
- Reset mid-frame: tx returns to 1 immediately (asynchronously), the partial frame is abandoned, and the pointer resets to 0.

## Timing
- Grant latency: req_ready asserts in the same cycle req_valid is sampled in IDLE. tx falls on the next posedge.
- Frame length F = BAUD_DIV*(1+DATA_WIDTH+P+STOP_BITS) cycles, where P=1 with parity enabled, else 0.
- Defaults without parity: F=160.
- At least one IDLE cycle separates frames, so back-to-back grant period is F+1 (161 at defaults).
- grant_id is stable from the grant cycle until the next grant.

## Configuration
- Macro UART_TX_ARB_PARITY_EN.
- Defined: the PARITY state is included, with an even-parity bit after the data bits, and P=1.
- Undefined: the PARITY state and its logic are not compiled; DATA goes directly to STOP, and P=0.

## Structure
- Shared package uart_ctrl_pkg holds:
  - the state enum uart_tx_state_e
  - an even-parity function
  - localparams for default BAUD_DIV and DATA_WIDTH, also used by the tx/rx agent BFMs
- Sub-module uart_baud_counter: a BAUD_DIV counter with a clear input and a one-cycle bit_tick output.

## Test plan
- Reset, then idle for 50 cycles -> tx=1, busy=0, req_ready=0 throughout.
- Only req_valid[2] asserted, data 8'hA5, defaults, no parity:
  - req_ready=4'b0100 for one cycle, grant_id=2.
  - tx shows 0, then 1,0,1,0,0,1,0,1, then 1, each 16 cycles; busy high for 160 cycles.
- All req_valid held high with data 8'h00/11/22/33 -> grants in order 0,1,2,3,0, one grant every 161 cycles.
- With UART_TX_ARB_PARITY_EN defined, data 8'h07 -> parity bit 1 follows data; frame is 176 cycles.
- req_valid[1] pulsed for 1 cycle while busy -> no grant to requester 1 after the current frame.
- areset pulled low at cycle 40 of a frame -> tx=1 and busy=0 within the same cycle. After release, the next grant search starts from requester 0.
